// File: rtl/led_dec_ctrl.sv
// led_dec_ctrl: debounced switch/button front end, manual/scan/hold select FSM
// and registered one-hot LED decode for the 2-to-3 LED decoder.
module led_dec_ctrl #(
  parameter int DB_CYCLES   = 4,
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] switch,
  input  logic       mode_btn,
  output logic [1:0] sel,
  output logic [2:0] led,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {MANUAL = 2'b00, SCAN = 2'b01, HOLD = 2'b10} state_e;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  state_e           state_q, state_d;
  logic [1:0]       sw_s1_q, sw_s2_q, sw_db_q, sw_db_d, sel_q, sel_d;
  logic             btn_s1_q, btn_s2_q, btn_db_q, btn_db_d, btn_prev_q, btn_ev;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, btn_cnt_q, btn_cnt_d, step_q, step_d;
  logic [2:0]       led_q;
  always_comb begin
    sw_cnt_d  = (sw_s2_q == sw_db_q || sw_cnt_q == DB_LAST) ? '0 : sw_cnt_q + 1'b1;
    sw_db_d   = (sw_s2_q != sw_db_q && sw_cnt_q == DB_LAST) ? sw_s2_q : sw_db_q;
    btn_cnt_d = (btn_s2_q == btn_db_q || btn_cnt_q == DB_LAST) ? '0 : btn_cnt_q + 1'b1;
    btn_db_d  = (btn_s2_q != btn_db_q && btn_cnt_q == DB_LAST) ? btn_s2_q : btn_db_q;
  end
  assign btn_ev = btn_db_q & ~btn_prev_q;
  // A button event on a step wrap changes mode and drops the step.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
    case (state_q)
      MANUAL: begin
        state_d = btn_ev ? SCAN : MANUAL;
        sel_d   = btn_ev ? 2'b01 : sw_db_q;
        step_d  = btn_ev ? '0 : step_q;
      end
      SCAN: begin
        state_d = btn_ev ? HOLD : SCAN;
        if (!btn_ev) begin
          step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
          sel_d  = (step_q != STEP_LAST) ? sel_q : (sel_q == 2'b11) ? 2'b01 : sel_q + 2'b01;
        end
      end
      HOLD: begin
        state_d = btn_ev ? MANUAL : HOLD;
        sel_d   = btn_ev ? sw_db_q : sel_q;
      end
      default: begin
        state_d = MANUAL;
        sel_d   = 2'b00;
        step_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MANUAL;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_db_q    <= '0;
      sw_cnt_q   <= '0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      btn_cnt_q  <= '0;
      step_q     <= '0;
      sel_q      <= 2'b00;
      led_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      sw_s1_q    <= switch;
      sw_s2_q    <= sw_s1_q;
      sw_db_q    <= sw_db_d;
      sw_cnt_q   <= sw_cnt_d;
      btn_s1_q   <= mode_btn;
      btn_s2_q   <= btn_s1_q;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      btn_cnt_q  <= btn_cnt_d;
      step_q     <= step_d;
      sel_q      <= sel_d;
      led_q      <= {sel_q == 2'b11, sel_q == 2'b10, sel_q == 2'b01};
    end
  end
  assign sel  = sel_q;
  assign led  = led_q;
  assign mode = state_q;
endmodule

// File: tb/tb_led_dec_ctrl.sv
// tb_led_dec_ctrl: directed checks of reset, debounce latency, bounce rejection,
// scan sequencing, hold/return, mid-scan reset and button/step collision.
module tb_led_dec_ctrl;
  logic       clk = 1'b0, rst = 1'b1, mode_btn = 1'b0;
  logic [1:0] switch = 2'b00, sel, mode;
  logic [2:0] led;
  int checks = 0, errors = 0;
  led_dec_ctrl dut (.clk(clk), .rst(rst), .switch(switch), .mode_btn(mode_btn),
                    .sel(sel), .led(led), .mode(mode));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_sel(input logic [1:0] target);
    int n = 0;
    while (sel !== target && n < 100) begin
      step(1);
      n++;
    end
    chk("wait_sel_timeout", {3'b000, n >= 100}, 4'h0);
  endtask
  initial begin
    switch = 2'b11; mode_btn = 1'b1;
    step(1);
    chk("rst1_sel", {2'b0, sel}, 4'h0); chk("rst1_led", {1'b0, led}, 4'h0); chk("rst1_mode", {2'b0, mode}, 4'h0);
    step(1);
    chk("rst2_sel", {2'b0, sel}, 4'h0); chk("rst2_led", {1'b0, led}, 4'h0); chk("rst2_mode", {2'b0, mode}, 4'h0);
    rst = 1'b0; switch = 2'b00; mode_btn = 1'b0;
    step(3);
    chk("idle_sel", {2'b0, sel}, 4'h0);
    // clean 00->10: sel after edge 6, led after edge 7
    switch = 2'b10;
    step(6);
    chk("lat_sel_e5", {2'b0, sel}, 4'h0);
    step(1);
    chk("lat_sel_e6", {2'b0, sel}, 4'h2); chk("lat_led_e6", {1'b0, led}, 4'h0);
    step(1);
    chk("lat_led_e7", {1'b0, led}, 4'h2);
    switch = 2'b00;
    step(12);
    chk("back_led", {1'b0, led}, 4'h0); chk("back_sel", {2'b0, sel}, 4'h0);
    // bounce 01/00 every 2 cycles then hold 01
    switch = 2'b01; step(2);
    switch = 2'b00; step(2);
    chk("bnc_sel_mid", {2'b0, sel}, 4'h0);
    switch = 2'b01; step(6);
    chk("bnc_sel_e9", {2'b0, sel}, 4'h0); chk("bnc_led_e9", {1'b0, led}, 4'h0);
    step(1);
    chk("bnc_sel_e10", {2'b0, sel}, 4'h1); chk("bnc_led_e10", {1'b0, led}, 4'h0);
    step(1);
    chk("bnc_led_e11", {1'b0, led}, 4'h1);
    // scan: press held, entry at edge 6, wraps every 8 edges
    mode_btn = 1'b1; step(6);
    chk("scan_mode_e5", {2'b0, mode}, 4'h0);
    step(1);
    chk("scan_mode_e6", {2'b0, mode}, 4'h1); chk("scan_sel_e6", {2'b0, sel}, 4'h1);
    step(7);
    chk("scan_sel_e13", {2'b0, sel}, 4'h1);
    step(1);
    chk("scan_sel_e14", {2'b0, sel}, 4'h2);
    step(1);
    chk("scan_led_e15", {1'b0, led}, 4'h2);
    step(7);
    chk("scan_sel_e22", {2'b0, sel}, 4'h3);
    step(1);
    chk("scan_led_e23", {1'b0, led}, 4'h4);
    step(7);
    chk("scan_sel_e30", {2'b0, sel}, 4'h1); chk("scan_mode_held", {2'b0, mode}, 4'h1);
    step(1);
    chk("scan_led_e31", {1'b0, led}, 4'h1);
    // hold: press right after sel reaches 11
    mode_btn = 1'b0;
    wait_sel(2'b11);
    mode_btn = 1'b1; step(6);
    chk("hold_mode_pre", {2'b0, mode}, 4'h1); chk("hold_sel_pre", {2'b0, sel}, 4'h3);
    step(1);
    chk("hold_mode", {2'b0, mode}, 4'h2); chk("hold_sel", {2'b0, sel}, 4'h3);
    mode_btn = 1'b0; switch = 2'b10;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("hold_led", {1'b0, led}, 4'h4);
    end
    chk("hold_mode_end", {2'b0, mode}, 4'h2); chk("hold_sel_end", {2'b0, sel}, 4'h3);
    mode_btn = 1'b1; step(6);
    chk("ret_mode_pre", {2'b0, mode}, 4'h2);
    step(1);
    chk("ret_mode", {2'b0, mode}, 4'h0); chk("ret_sel", {2'b0, sel}, 4'h2); chk("ret_led_pre", {1'b0, led}, 4'h4);
    step(1);
    chk("ret_led", {1'b0, led}, 4'h2);
    // mid-scan reset
    mode_btn = 1'b0; step(10);
    mode_btn = 1'b1; step(7);
    chk("rs_scan_mode", {2'b0, mode}, 4'h1); chk("rs_scan_sel", {2'b0, sel}, 4'h1);
    mode_btn = 1'b0; step(3);
    rst = 1'b1; step(1);
    chk("rs_mode", {2'b0, mode}, 4'h0); chk("rs_sel", {2'b0, sel}, 4'h0); chk("rs_led", {1'b0, led}, 4'h0);
    rst = 1'b0; step(1);
    chk("rs_post_mode", {2'b0, mode}, 4'h0); chk("rs_post_sel", {2'b0, sel}, 4'h0);
    step(10);
    chk("rs_resync_sel", {2'b0, sel}, 4'h2);
    // collision: press lands on the second wrap after entry
    mode_btn = 1'b1; step(7);
    chk("col_entry_mode", {2'b0, mode}, 4'h1); chk("col_entry_sel", {2'b0, sel}, 4'h1);
    mode_btn = 1'b0; step(9);
    mode_btn = 1'b1; step(5);
    chk("col_sel_e14", {2'b0, sel}, 4'h2); chk("col_mode_e14", {2'b0, mode}, 4'h1);
    step(1);
    chk("col_mode_e15", {2'b0, mode}, 4'h1);
    step(1);
    chk("col_mode_e16", {2'b0, mode}, 4'h2); chk("col_sel_e16", {2'b0, sel}, 4'h2);
    mode_btn = 1'b0; step(10);
    chk("col_sel_frozen", {2'b0, sel}, 4'h2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
